agc_sequencer: RTL and testbench
================================

AGC_SEQUENCER -- requirements
Module: agc_sequencer

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50000000, meaning system clock frequency in Hz (informational; all timing is in cycles).
REQ-002 The block SHALL have parameter HGA_SETTLE_CYCLES, default 5000, meaning wait after any HGA bypass change.
REQ-003 The block SHALL have parameter PGA_SETTLE_CYCLES, default 500, meaning wait after a PGA-only change.
REQ-004 The block SHALL have parameter MEAS_TIMEOUT_CYCLES, default 100000, meaning maximum wait for valid_i.
REQ-005 The block SHALL have parameter HIGH_THRESH, default 16'hC000, meaning power above which gain steps down.
REQ-006 The block SHALL have parameter LOW_THRESH, default 16'h1000, meaning power below which gain steps up.
REQ-007 The block SHALL have port clk, input, 1 bit, meaning the single system clock.
REQ-008 The block SHALL have port rst, input, 1 bit, meaning synchronous active-high reset.
REQ-009 The block SHALL have port start_i, input, 1 bit, meaning a pulse that begins an AGC run.
REQ-010 The block SHALL have port abort_i, input, 1 bit, meaning stop the run and return to IDLE.
REQ-011 The block SHALL have port power_i, input, 16 bits, meaning unsigned Goertzel power result.
REQ-012 The block SHALL have port valid_i, input, 1 bit, meaning power_i is valid this cycle.
REQ-013 The block SHALL have port dc_block_en_o, output, 1 bit, meaning enable for the DC blocker.
REQ-014 The block SHALL have port goertzel_start_o, output, 1 bit, meaning a one-cycle measurement start pulse.
REQ-015 The block SHALL have port hga_bypass_o, output, 1 bit, meaning that 1 bypasses the high-gain stage.
REQ-016 The block SHALL have port pga_gain_o, output, 3 bits, meaning the PGA gain code.
REQ-017 The block SHALL have port busy_o, output, 1 bit, meaning the state is not IDLE.
REQ-018 The block SHALL have port locked_o, output, 1 bit, meaning the last run converged.
REQ-019 The block SHALL have port timeout_o, output, 1 bit, meaning the last run ended on a measurement timeout.

Function
REQ-020 The block SHALL keep an internal 4-bit gain index g (0..15) with hga_bypass_o = ~g[3] and pga_gain_o = g[2:0]; 0 is minimum gain and 15 is maximum gain.
REQ-021 The block SHALL implement the states IDLE, MEAS_START, MEAS_WAIT, EVAL, SETTLE.
REQ-022 In IDLE, start_i SHALL clear locked_o and timeout_o, set dc_block_en_o=1 and go to MEAS_START; g SHALL be retained from the previous run.
REQ-023 MEAS_START SHALL assert goertzel_start_o for exactly one cycle, clear the timeout counter, and go to MEAS_WAIT.
REQ-024 In MEAS_WAIT, valid_i SHALL capture power_i and go to EVAL; valid_i in any other state SHALL be ignored.
REQ-025 If valid_i has not arrived after MEAS_TIMEOUT_CYCLES cycles in MEAS_WAIT, the block SHALL set timeout_o=1, clear dc_block_en_o and go to IDLE.
REQ-026 In EVAL, the block SHALL decide in one cycle:
- power > HIGH_THRESH and g > 0: g <= g-1, go to SETTLE.
- power < LOW_THRESH and g < 15: g <= g+1, go to SETTLE.
- otherwise, including the saturated cases at g=0 or g=15: locked_o <= 1, dc_block_en_o <= 0, go to IDLE.
- Comparisons are strict; power equal to a threshold is in band.
REQ-027 The settle length SHALL be HGA_SETTLE_CYCLES if g[3] changed, otherwise PGA_SETTLE_CYCLES; SETTLE SHALL last exactly that many cycles and then go to MEAS_START.
REQ-028 A settle parameter of 0 SHALL give a single-cycle SETTLE.
REQ-029 Gain outputs SHALL be registered and SHALL change in the cycle after EVAL, and never during MEAS_WAIT.
REQ-030 abort_i SHALL force IDLE and dc_block_en_o=0 in any state, retaining g and leaving locked_o and timeout_o at 0; if abort_i and start_i are asserted in the same cycle, abort_i SHALL win.
REQ-031 start_i SHALL be ignored while busy_o=1.
REQ-032 Latency from start_i to goertzel_start_o SHALL be 2 cycles (IDLE->MEAS_START registered, pulse in MEAS_START).

Reset
REQ-033 rst SHALL, synchronously, set state=IDLE, g=15 (hga_bypass_o=0, pga_gain_o=3'b111), and set dc_block_en_o, goertzel_start_o, busy_o, locked_o and timeout_o to 0.
REQ-034 rst asserted mid-run SHALL take priority over all other inputs and discard any in-flight measurement.

Verification
REQ-035 The bench SHALL cover in-band convergence: after reset, start_i, then valid_i with power 16'h8000 -> locked_o=1 within 1 cycle after EVAL, g stays 15, exactly one goertzel_start_o pulse.
REQ-036 The bench SHALL cover the HGA crossing: g=8, power 16'hF000 then 16'h8000 -> g=7, hga_bypass_o 0->1, SETTLE lasting HGA_SETTLE_CYCLES, then locked_o=1.
REQ-037 The bench SHALL cover timeout: start_i with no valid_i -> timeout_o=1 after MEAS_TIMEOUT_CYCLES, busy_o=0, dc_block_en_o=0.
REQ-038 The bench SHALL cover saturation: g=0 with power 16'hFFFF -> no gain change, locked_o=1; g=15 with power 0 -> locked_o=1.
REQ-039 The bench SHALL cover abort and reset: abort_i during SETTLE -> IDLE next cycle with g retained; rst during MEAS_WAIT followed by a late valid_i -> no effect, outputs at reset values.
REQ-040 The bench SHALL cover threshold boundaries: power equal to HIGH_THRESH and power equal to LOW_THRESH -> locked_o=1, no gain step.

Source files
------------

// File: rtl/agc_sequencer.sv
// AGC run sequencer: measures Goertzel power, steps a 4-bit gain index up or
// down with settle delays, and stops when power lands in band or gain saturates.
module agc_sequencer #(
    parameter int unsigned CLK_FREQ            = 50000000,
    parameter int unsigned HGA_SETTLE_CYCLES   = 5000,
    parameter int unsigned PGA_SETTLE_CYCLES   = 500,
    parameter int unsigned MEAS_TIMEOUT_CYCLES = 100000,
    parameter logic [15:0] HIGH_THRESH         = 16'hC000,
    parameter logic [15:0] LOW_THRESH          = 16'h1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [15:0] power_i,
    input  logic        valid_i,
    output logic        dc_block_en_o,
    output logic        goertzel_start_o,
    output logic        hga_bypass_o,
    output logic [2:0]  pga_gain_o,
    output logic        busy_o,
    output logic        locked_o,
    output logic        timeout_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MEAS_START,
        S_MEAS_WAIT,
        S_EVAL,
        S_SETTLE
    } state_t;

    state_t      r_state;
    logic [3:0]  r_g;
    logic [15:0] r_power;
    logic [31:0] r_tcnt;
    logic [31:0] r_scnt;
    logic [31:0] r_settle_last;
    logic        r_dc_en;
    logic        r_gstart;
    logic        r_locked;
    logic        r_timeout;

    logic        w_step_down;
    logic        w_step_up;
    logic [3:0]  w_g_next;
    logic [31:0] w_settle_len;

    // Clock frequency is documentation only; every delay is counted in cycles.
    if (CLK_FREQ == 0) begin : g_clk_freq_unset
    end

    assign w_step_down  = (r_power > HIGH_THRESH) && (r_g != 4'd0);
    assign w_step_up    = (r_power < LOW_THRESH) && (r_g != 4'd15);
    assign w_g_next     = w_step_down ? (r_g - 4'd1) : (w_step_up ? (r_g + 4'd1) : r_g);
    assign w_settle_len = (w_g_next[3] != r_g[3]) ? HGA_SETTLE_CYCLES : PGA_SETTLE_CYCLES;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_g           <= 4'd15;
            r_power       <= 16'd0;
            r_tcnt        <= 32'd0;
            r_scnt        <= 32'd0;
            r_settle_last <= 32'd0;
            r_dc_en       <= 1'b0;
            r_gstart      <= 1'b0;
            r_locked      <= 1'b0;
            r_timeout     <= 1'b0;
        end else if (abort_i) begin
            r_state   <= S_IDLE;
            r_dc_en   <= 1'b0;
            r_gstart  <= 1'b0;
            r_locked  <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_gstart <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_locked  <= 1'b0;
                        r_timeout <= 1'b0;
                        r_dc_en   <= 1'b1;
                        r_state   <= S_MEAS_START;
                    end
                end
                S_MEAS_START: begin
                    r_gstart <= 1'b1;
                    r_tcnt   <= 32'd0;
                    r_state  <= S_MEAS_WAIT;
                end
                S_MEAS_WAIT: begin
                    if (valid_i) begin
                        r_power <= power_i;
                        r_state <= S_EVAL;
                    end else if ((r_tcnt + 32'd1) >= MEAS_TIMEOUT_CYCLES) begin
                        r_timeout <= 1'b1;
                        r_dc_en   <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_tcnt <= r_tcnt + 32'd1;
                    end
                end
                S_EVAL: begin
                    if (w_step_down || w_step_up) begin
                        r_g           <= w_g_next;
                        r_scnt        <= 32'd0;
                        // A zero-length settle still occupies one SETTLE cycle.
                        r_settle_last <= (w_settle_len == 32'd0) ? 32'd0 : (w_settle_len - 32'd1);
                        r_state       <= S_SETTLE;
                    end else begin
                        r_locked <= 1'b1;
                        r_dc_en  <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                S_SETTLE: begin
                    if (r_scnt >= r_settle_last) begin
                        r_state <= S_MEAS_START;
                    end else begin
                        r_scnt <= r_scnt + 32'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dc_block_en_o    = r_dc_en;
    assign goertzel_start_o = r_gstart;
    assign hga_bypass_o     = ~r_g[3];
    assign pga_gain_o       = r_g[2:0];
    assign busy_o           = (r_state != S_IDLE);
    assign locked_o         = r_locked;
    assign timeout_o        = r_timeout;

endmodule

// File: tb/tb_agc_sequencer.sv
// Directed bench for agc_sequencer: a vector table walks the gain index through
// convergence, thresholds, HGA crossings and saturation; hand sequences cover the rest.
module tb_agc_sequencer;

    localparam int H = 20;
    localparam int P = 5;
    localparam int T = 30;
    localparam int NV = 28;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [15:0] power_i = 16'd0;
    logic        valid_i = 1'b0;
    logic        dc_block_en_o;
    logic        goertzel_start_o;
    logic        hga_bypass_o;
    logic [2:0]  pga_gain_o;
    logic        busy_o;
    logic        locked_o;
    logic        timeout_o;

    int errors = 0;
    int checks = 0;
    int gs_count = 0;

    typedef struct {
        logic        start;
        logic [15:0] power;
        logic [3:0]  exp_g;
        logic        exp_locked;
        int          exp_wait;
    } vec_t;

    vec_t vecs [NV];

    agc_sequencer #(
        .CLK_FREQ(50000000),
        .HGA_SETTLE_CYCLES(H),
        .PGA_SETTLE_CYCLES(P),
        .MEAS_TIMEOUT_CYCLES(T),
        .HIGH_THRESH(16'hC000),
        .LOW_THRESH(16'h1000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start_i(start_i),
        .abort_i(abort_i),
        .power_i(power_i),
        .valid_i(valid_i),
        .dc_block_en_o(dc_block_en_o),
        .goertzel_start_o(goertzel_start_o),
        .hga_bypass_o(hga_bypass_o),
        .pga_gain_o(pga_gain_o),
        .busy_o(busy_o),
        .locked_o(locked_o),
        .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (goertzel_start_o) gs_count <= gs_count + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] cur_g();
        return {~hga_bypass_o, pga_gain_o};
    endfunction

    // Optionally pulse start, wait for the measurement pulse, then return one power sample.
    task automatic run_meas(input logic do_start, input logic [15:0] pw, output int n);
        n = 0;
        if (do_start) begin
            start_i = 1'b1;
            @(negedge clk);
            start_i = 1'b0;
            n = 1;
        end
        while (!goertzel_start_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (goertzel_start_o) begin
            valid_i = 1'b1;
            power_i = pw;
            @(negedge clk);
            valid_i = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        int gs_snap;

        vecs[0]  = '{1'b1, 16'h8000, 4'd15, 1'b1, 2};
        vecs[1]  = '{1'b1, 16'h0000, 4'd15, 1'b1, 2};
        vecs[2]  = '{1'b1, 16'hC000, 4'd15, 1'b1, 2};
        vecs[3]  = '{1'b1, 16'h1000, 4'd15, 1'b1, 2};
        vecs[4]  = '{1'b1, 16'hC001, 4'd14, 1'b0, 2};
        vecs[5]  = '{1'b0, 16'hF000, 4'd13, 1'b0, P + 1};
        vecs[6]  = '{1'b0, 16'hFFFF, 4'd12, 1'b0, P + 1};
        vecs[7]  = '{1'b0, 16'hF000, 4'd11, 1'b0, P + 1};
        vecs[8]  = '{1'b0, 16'hF000, 4'd10, 1'b0, P + 1};
        vecs[9]  = '{1'b0, 16'hF000, 4'd9,  1'b0, P + 1};
        vecs[10] = '{1'b0, 16'hF000, 4'd8,  1'b0, P + 1};
        vecs[11] = '{1'b0, 16'h8000, 4'd8,  1'b1, P + 1};
        vecs[12] = '{1'b1, 16'hF000, 4'd7,  1'b0, 2};
        vecs[13] = '{1'b0, 16'h8000, 4'd7,  1'b1, H + 1};
        vecs[14] = '{1'b1, 16'h0FFF, 4'd8,  1'b0, 2};
        vecs[15] = '{1'b0, 16'h0FFF, 4'd9,  1'b0, H + 1};
        vecs[16] = '{1'b0, 16'h8000, 4'd9,  1'b1, P + 1};
        vecs[17] = '{1'b1, 16'hF000, 4'd8,  1'b0, 2};
        vecs[18] = '{1'b0, 16'hF000, 4'd7,  1'b0, P + 1};
        vecs[19] = '{1'b0, 16'hF000, 4'd6,  1'b0, H + 1};
        vecs[20] = '{1'b0, 16'hF000, 4'd5,  1'b0, P + 1};
        vecs[21] = '{1'b0, 16'hF000, 4'd4,  1'b0, P + 1};
        vecs[22] = '{1'b0, 16'hF000, 4'd3,  1'b0, P + 1};
        vecs[23] = '{1'b0, 16'hF000, 4'd2,  1'b0, P + 1};
        vecs[24] = '{1'b0, 16'hF000, 4'd1,  1'b0, P + 1};
        vecs[25] = '{1'b0, 16'hF000, 4'd0,  1'b0, P + 1};
        vecs[26] = '{1'b0, 16'hFFFF, 4'd0,  1'b1, P + 1};
        vecs[27] = '{1'b1, 16'hFFFF, 4'd0,  1'b1, 2};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        $display("reset: g=%0d busy=%0b locked=%0b", cur_g(), busy_o, locked_o);
        check("reset_g", {28'd0, cur_g()}, 32'd15);
        check("reset_busy", {31'd0, busy_o}, 32'd0);
        check("reset_dc", {31'd0, dc_block_en_o}, 32'd0);
        check("reset_gstart", {31'd0, goertzel_start_o}, 32'd0);
        check("reset_locked", {31'd0, locked_o}, 32'd0);
        check("reset_timeout", {31'd0, timeout_o}, 32'd0);

        for (int i = 0; i < NV; i++) begin
            gs_snap = gs_count;
            run_meas(vecs[i].start, vecs[i].power, n);
            $display("vec %0d: power=%h wait=%0d g=%0d locked=%0b busy=%0b",
                     i, vecs[i].power, n, cur_g(), locked_o, busy_o);
            check($sformatf("vec%0d_wait", i), n, vecs[i].exp_wait);
            check($sformatf("vec%0d_g", i), {28'd0, cur_g()}, {28'd0, vecs[i].exp_g});
            check($sformatf("vec%0d_locked", i), {31'd0, locked_o}, {31'd0, vecs[i].exp_locked});
            check($sformatf("vec%0d_busy", i), {31'd0, busy_o}, {31'd0, ~vecs[i].exp_locked});
            check($sformatf("vec%0d_dc", i), {31'd0, dc_block_en_o}, {31'd0, ~vecs[i].exp_locked});
            check($sformatf("vec%0d_timeout", i), {31'd0, timeout_o}, 32'd0);
            check($sformatf("vec%0d_pulses", i), gs_count - gs_snap, 32'd1);
        end

        // Measurement timeout: no valid_i ever arrives.
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        n = 1;
        while (!goertzel_start_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("to_start_latency", n, 32'd2);
        check("to_dc_during", {31'd0, dc_block_en_o}, 32'd1);
        check("to_locked_cleared", {31'd0, locked_o}, 32'd0);
        n = 0;
        while (busy_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        $display("timeout: cycles=%0d timeout=%0b dc=%0b g=%0d", n, timeout_o, dc_block_en_o, cur_g());
        check("to_cycles", n, T);
        check("to_flag", {31'd0, timeout_o}, 32'd1);
        check("to_dc_after", {31'd0, dc_block_en_o}, 32'd0);
        check("to_locked", {31'd0, locked_o}, 32'd0);
        check("to_g_kept", {28'd0, cur_g()}, 32'd0);

        // Abort during SETTLE.
        run_meas(1'b1, 16'h0000, n);
        check("ab_in_settle_busy", {31'd0, busy_o}, 32'd1);
        check("ab_g_stepped", {28'd0, cur_g()}, 32'd1);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        gs_snap = gs_count;
        $display("abort: busy=%0b g=%0d dc=%0b", busy_o, cur_g(), dc_block_en_o);
        check("ab_busy", {31'd0, busy_o}, 32'd0);
        check("ab_g_kept", {28'd0, cur_g()}, 32'd1);
        check("ab_dc", {31'd0, dc_block_en_o}, 32'd0);
        check("ab_locked", {31'd0, locked_o}, 32'd0);
        check("ab_timeout", {31'd0, timeout_o}, 32'd0);
        repeat (P + 5) @(negedge clk);
        check("ab_no_restart", gs_count - gs_snap, 32'd0);

        // Abort wins over a simultaneous start.
        abort_i = 1'b1;
        start_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        $display("abort+start: busy=%0b pulses=%0d", busy_o, gs_count - gs_snap);
        check("abst_busy", {31'd0, busy_o}, 32'd0);
        check("abst_no_pulse", gs_count - gs_snap, 32'd0);

        // Reset mid-measurement, followed by a late valid_i.
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        n = 1;
        while (!goertzel_start_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rst_start_latency", n, 32'd2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        gs_snap = gs_count;
        valid_i = 1'b1;
        power_i = 16'h0000;
        @(negedge clk);
        valid_i = 1'b0;
        repeat (P + 5) @(negedge clk);
        $display("reset mid-run: busy=%0b g=%0d locked=%0b", busy_o, cur_g(), locked_o);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_hga", {31'd0, hga_bypass_o}, 32'd0);
        check("rst_pga", {29'd0, pga_gain_o}, 32'd7);
        check("rst_dc", {31'd0, dc_block_en_o}, 32'd0);
        check("rst_locked", {31'd0, locked_o}, 32'd0);
        check("rst_timeout", {31'd0, timeout_o}, 32'd0);
        check("rst_no_pulse", gs_count - gs_snap, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
